// File: rtl/veda_core_if.sv
// rtl/veda_core_if.sv - instruction and data memory port bundle for veda_core
interface veda_core_if;
  logic        mode1;
  logic [31:0] address1;
  logic [31:0] data_in1;
  logic [31:0] data_out1;
  logic        mode2;
  logic [31:0] address2;
  logic [31:0] data_in2;
  logic [31:0] data_out2;

  modport master (
    output mode1, address1, data_in1, mode2, address2, data_in2,
    input  data_out1, data_out2
  );

  modport slave (
    input  mode1, address1, data_in1, mode2, address2, data_in2,
    output data_out1, data_out2
  );
endinterface

// File: rtl/veda_core.sv
// rtl/veda_core.sv - multicycle FETCH/DECODE/EXEC/MEM/WB core with a 32x32 register file
// Optional retired-instruction counter output enabled by VEDA_CORE_RETIRE_CNT_EN.
module veda_core #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  veda_core_if.master mem,
  output logic        halted,
  output logic [31:0] pc
`ifdef VEDA_CORE_RETIRE_CNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_BNE   = 6'b001011;
  localparam logic [5:0] FN_ADD   = 6'b000000;
  localparam logic [5:0] FN_SUB   = 6'b000001;
  localparam logic [5:0] FN_SLT   = 6'b001000;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, opc_q, opc_d;
  logic [31:0] res_q, res_d;
  logic [31:0] addr2_q, addr2_d;
  logic [31:0] wdata2_q, wdata2_d;
  logic        mode2_q, mode2_d;
  logic        halted_q, halted_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [5:0]  op, funct;
  logic [4:0]  fa;
  logic [31:0] imm;
  logic [4:0]  dec_a, dec_b, dec_c;
  logic        unused_ir;

  assign op        = ir_q[31:26];
  assign fa        = ir_q[25:21];
  assign funct     = ir_q[5:0];
  assign imm       = {{16{ir_q[15]}}, ir_q[15:0]};
  assign dec_a     = mem.data_out1[25:21];
  assign dec_b     = mem.data_out1[20:16];
  assign dec_c     = mem.data_out1[15:11];
  assign unused_ir = ^{ir_q[20:16], ir_q[10:6]};

`ifdef VEDA_CORE_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic        retire;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    opc_d    = opc_q;
    res_d    = res_q;
    addr2_d  = addr2_q;
    wdata2_d = wdata2_q;
    mode2_d  = 1'b1;
    halted_d = halted_q;
    regs_d   = regs_q;

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        ir_d    = mem.data_out1;
        opa_d   = (dec_a == 5'd0) ? 32'd0 : regs_q[dec_a];
        opb_d   = (dec_b == 5'd0) ? 32'd0 : regs_q[dec_b];
        opc_d   = (dec_c == 5'd0) ? 32'd0 : regs_q[dec_c];
        state_d = S_EXEC;
      end

      S_EXEC: begin
        // Unknown ops and funct codes fall through as a 3-cycle NOP.
        state_d = S_FETCH;
        pc_d    = pc_q + 32'd1;
        if (op == HALT_OP) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          case (op)
            OP_RTYPE: begin
              state_d = S_WB;
              case (funct)
                FN_ADD:  res_d = opb_q + opc_q;
                FN_SUB:  res_d = opb_q - opc_q;
                FN_SLT:  res_d = {31'd0, ($signed(opb_q) < $signed(opc_q))};
                default: state_d = S_FETCH;
              endcase
            end
            OP_ADDI: begin
              res_d   = opb_q + imm;
              state_d = S_WB;
            end
            OP_LW: begin
              addr2_d = opb_q + imm;
              state_d = S_MEM;
            end
            OP_SW: begin
              addr2_d  = opb_q + imm;
              wdata2_d = opa_q;
              mode2_d  = 1'b0;
              state_d  = S_MEM;
            end
            OP_BNE: begin
              if (opa_q != opb_q) pc_d = pc_q + imm;
            end
            default: ;
          endcase
        end
        // pc only moves in the cycle that finishes the instruction.
        if (state_d != S_FETCH) pc_d = pc_q;
      end

      S_MEM: begin
        if (op == OP_LW) begin
          res_d   = mem.data_out2;
          state_d = S_WB;
        end else begin
          pc_d    = pc_q + 32'd1;
          state_d = S_FETCH;
        end
      end

      S_WB: begin
        if (fa != 5'd0) regs_d[fa] = res_q;
        pc_d    = pc_q + 32'd1;
        state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

`ifdef VEDA_CORE_RETIRE_CNT_EN
  always_comb begin
    retire    = (state_q != S_HALT) && ((state_d == S_FETCH) || (state_d == S_HALT))
                && (state_q != S_FETCH);
    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      res_q    <= '0;
      addr2_q  <= '0;
      wdata2_q <= '0;
      mode2_q  <= 1'b1;
      halted_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
`ifdef VEDA_CORE_RETIRE_CNT_EN
      retired_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opc_q    <= opc_d;
      res_q    <= res_d;
      addr2_q  <= addr2_d;
      wdata2_q <= wdata2_d;
      mode2_q  <= mode2_d;
      halted_q <= halted_d;
      regs_q   <= regs_d;
`ifdef VEDA_CORE_RETIRE_CNT_EN
      retired_q <= retired_d;
`endif
    end
  end

  assign mem.mode1    = 1'b1;
  assign mem.address1 = pc_q;
  assign mem.data_in1 = 32'd0;
  assign mem.mode2    = mode2_q;
  assign mem.address2 = addr2_q;
  assign mem.data_in2 = wdata2_q;
  assign halted       = halted_q;
  assign pc           = pc_q;
`ifdef VEDA_CORE_RETIRE_CNT_EN
  assign retired      = retired_q;
`endif

endmodule
